// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Fetch-side and decode-side handshake bundle of fetch_queue.
//               master = surrounding pipeline (fetch stage + decode),
//               slave  = the fetch queue itself.
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int XLEN       = 32,
    parameter int INST_WIDTH = 32
);
    // fetch stage -> queue
    logic                  fetch_valid;
    logic [XLEN-1:0]       fetch_pc;
    logic [INST_WIDTH-1:0] fetch_instr;
    // queue -> fetch stage
    logic                  fetch_stall;
    // queue -> decode
    logic                  dec_valid;
    logic [XLEN-1:0]       dec_pc;
    logic [INST_WIDTH-1:0] dec_instr;
    // decode -> queue
    logic                  dec_ready;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output fetch_instr,
        output dec_ready,
        input  fetch_stall,
        input  dec_valid,
        input  dec_pc,
        input  dec_instr
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  fetch_instr,
        input  dec_ready,
        output fetch_stall,
        output dec_valid,
        output dec_pc,
        output dec_instr
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : In-order instruction buffer between the fetch stage and
//               decode. Circular buffer of DEPTH {pc, instr} entries with a
//               valid/ready head, an early stall to fetch that reserves a
//               slot for the one in-flight fetch result, a sticky overflow
//               flag, and synchronous clear on pipeline flush.
//               Optional macro FETCHQ_BYPASS_EN: when the queue is empty a
//               valid fetch result is presented to decode in the same cycle
//               and is not stored if decode accepts it immediately.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int XLEN       = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   flush,
    fetch_queue_if.slave                bus,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = XLEN + INST_WIDTH;

    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   STALL_CNT = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Storage is deliberately not reset; contents are only observable
    // through dec_pc/dec_instr while dec_valid is high.
    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_nxt;
    logic             ovf_q;

    logic             q_valid;     // stored head entry exists
    logic             full;
    logic             pop;         // stored head consumed by decode
    logic             push;        // fetch result written into storage
    logic             ovf_evt;     // fetch result dropped because full
    logic [ENT_W-1:0] head;

    assign q_valid = (count_q != '0);
    assign full    = (count_q == FULL_CNT);
    assign head    = mem[rd_ptr];

    assign pop     = q_valid && bus.dec_ready && !flush;
    // A pop in the same cycle frees the slot, so a full queue can still
    // accept a new entry while its head is being consumed.
    assign ovf_evt = bus.fetch_valid && !flush && full && !pop;

`ifdef FETCHQ_BYPASS_EN
    logic bypass;     // empty queue: forward the fetch result directly
    logic byp_taken;  // forwarded entry accepted, never stored

    assign bypass    = !q_valid && bus.fetch_valid && !flush;
    assign byp_taken = bypass && bus.dec_ready;
    assign push      = bus.fetch_valid && !flush && (!full || pop) && !byp_taken;

    assign bus.dec_valid = q_valid || bypass;
    assign bus.dec_pc    = bypass ? bus.fetch_pc    : head[ENT_W-1:INST_WIDTH];
    assign bus.dec_instr = bypass ? bus.fetch_instr : head[INST_WIDTH-1:0];
`else
    assign push      = bus.fetch_valid && !flush && (!full || pop);

    assign bus.dec_valid = q_valid;
    assign bus.dec_pc    = head[ENT_W-1:INST_WIDTH];
    assign bus.dec_instr = head[INST_WIDTH-1:0];
`endif

    // Stall from registered occupancy only: the fetch stage's output is
    // registered, so one more result may land after stall rises and the
    // DEPTH-1 threshold keeps a slot free for it.
    assign bus.fetch_stall = (count_q >= STALL_CNT);

    assign count        = count_q;
    assign overflow_err = ovf_q;

    // Occupancy update: push and pop together leave the count unchanged.
    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_nxt = count_q - CNT_ONE;
        end
    end

    // Entry storage write at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.fetch_pc, bus.fetch_instr};
        end
    end

    // Pointers and occupancy; flush clears everything and outranks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q <= count_nxt;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_evt) begin
            ovf_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue: directed vector table,
//               hand-written reset/bypass sequences, and randomized traffic
//               compared against a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] count;
    logic       overflow_err;

    int total = 0;
    int bad   = 0;

    fetch_queue_if #(.XLEN(32), .INST_WIDTH(32)) bus ();

    fetch_queue #(.XLEN(32), .INST_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] mq[$];
    bit          m_ovf;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit model_bypass();
`ifdef FETCHQ_BYPASS_EN
        return (mq.size() == 0) && bus.fetch_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    // Compare outputs against the model (call before the active edge).
    function automatic void model_check();
        bit byp;
        byp = model_bypass();
        chk("m_valid", 64'(bus.dec_valid), 64'((mq.size() != 0) || byp));
        chk("m_count", 64'(count), 64'(mq.size()));
        chk("m_stall", 64'(bus.fetch_stall), 64'(mq.size() >= DEPTH - 1));
        chk("m_ovf", 64'(overflow_err), 64'(m_ovf));
        if (mq.size() != 0) begin
            chk("m_pc", 64'(bus.dec_pc), 64'(mq[0][63:32]));
            chk("m_instr", 64'(bus.dec_instr), 64'(mq[0][31:0]));
        end else if (byp) begin
            chk("m_byp_pc", 64'(bus.dec_pc), 64'(bus.fetch_pc));
            chk("m_byp_instr", 64'(bus.dec_instr), 64'(bus.fetch_instr));
        end
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_update();
        bit pop;
        if (flush) begin
            mq.delete();
            return;
        end
        if (model_bypass() && bus.dec_ready) return;
        pop = (mq.size() != 0) && bus.dec_ready;
        if (pop) void'(mq.pop_front());
        if (bus.fetch_valid) begin
            if (mq.size() < DEPTH) mq.push_back({bus.fetch_pc, bus.fetch_instr});
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic drive(input bit fv, input logic [31:0] pc, input bit rdy, input bit fl);
        bus.fetch_valid = fv;
        bus.fetch_pc    = pc;
        bus.fetch_instr = ins_of(pc);
        bus.dec_ready   = rdy;
        flush           = fl;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(bus.dec_valid), 64'd0);
        chk("rst_stall", 64'(bus.fetch_stall), 64'd0);
        chk("rst_ovf", 64'(overflow_err), 64'd0);
        mq.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          fv;
        logic [31:0] pc;
        bit          rdy;
        bit          fl;
        bit          ev;
        logic [31:0] epc;
        int          ecnt;
        bit          est;
        bit          eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit fv, input logic [31:0] pc, input bit rdy,
                                input bit fl, input bit ev, input logic [31:0] epc,
                                input int ecnt, input bit est, input bit eovf);
        vec_t v;
        v.fv = fv; v.pc = pc; v.rdy = rdy; v.fl = fl;
        v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.est = est; v.eovf = eovf;
        vecs.push_back(v);
    endfunction

    bit prev_stall;

    initial begin
        // Expected values are the outputs seen before each vector's clock edge.
        // streaming 0x0/0x4/0x8 with decode always ready
        add(1, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0);
        add(1, 32'h4, 1, 0, 1, 32'h0, 1, 0, 0);
        add(1, 32'h8, 1, 0, 1, 32'h4, 1, 0, 0);
        add(0, 32'h0, 1, 0, 1, 32'h8, 1, 0, 0);
        add(0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0);
        // fill with decode stalled: stall at 7, in-flight push reaches 8
        for (int i = 0; i < DEPTH; i++)
            add(1, 32'h10 + 32'(4 * i), 0, 0, i != 0, 32'h10, i, i >= DEPTH - 1, 0);
        add(0, 32'h0, 0, 0, 1, 32'h10, 8, 1, 0);
        // full with simultaneous push and pop
        add(1, 32'h40, 1, 0, 1, 32'h10, 8, 1, 0);
        add(0, 32'h0, 0, 0, 1, 32'h14, 8, 1, 0);
        // overflow while full
        add(1, 32'h44, 0, 0, 1, 32'h14, 8, 1, 0);
        add(0, 32'h0, 0, 0, 1, 32'h14, 8, 1, 1);
        // drain to 5
        add(0, 32'h0, 1, 0, 1, 32'h14, 8, 1, 1);
        add(0, 32'h0, 1, 0, 1, 32'h18, 7, 1, 1);
        add(0, 32'h0, 1, 0, 1, 32'h1c, 6, 0, 1);
        // flush at count 5 with push and pop requested
        add(1, 32'h50, 1, 1, 1, 32'h20, 5, 0, 1);
        add(1, 32'h200, 0, 0, 0, 32'h0, 0, 0, 1);
        add(0, 32'h0, 0, 0, 1, 32'h200, 1, 0, 1);
        // refill to full, then flush: stall must drop next cycle
        for (int i = 0; i < DEPTH - 1; i++)
            add(1, 32'h300 + 32'(4 * i), 0, 0, 1, 32'h200, i + 1, i + 1 >= DEPTH - 1, 1);
        add(0, 32'h0, 0, 1, 1, 32'h200, 8, 1, 1);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 1);

        drive(1'b0, 32'h0, 1'b0, 1'b0);
        mq.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

`ifndef FETCHQ_BYPASS_EN
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].rdy, vecs[i].fl);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(bus.dec_valid), 64'(vecs[i].ev));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].ecnt));
            chk($sformatf("v%0d_stall", i), 64'(bus.fetch_stall), 64'(vecs[i].est));
            chk($sformatf("v%0d_ovf", i), 64'(overflow_err), 64'(vecs[i].eovf));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_pc", i), 64'(bus.dec_pc), 64'(vecs[i].epc));
                chk($sformatf("v%0d_instr", i), 64'(bus.dec_instr), 64'(ins_of(vecs[i].epc)));
            end
            model_check();
            model_update();
            @(posedge clk);
            #1;
        end
`else
        // bypass: empty queue, fetch valid and decode ready in the same cycle
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        #1;
        chk("byp_valid", 64'(bus.dec_valid), 64'd1);
        chk("byp_pc", 64'(bus.dec_pc), 64'h100);
        chk("byp_instr", 64'(bus.dec_instr), 64'(ins_of(32'h100)));
        cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("byp_count", 64'(count), 64'd0);
        chk("byp_valid_after", 64'(bus.dec_valid), 64'd0);
        // bypass with decode not ready: entry is stored
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("byp_store_count", 64'(count), 64'd1);
        chk("byp_store_pc", 64'(bus.dec_pc), 64'h104);
        cycle();
`endif

        // asynchronous reset in the middle of operation
        drive(1'b1, 32'h600, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h604, 1'b0, 1'b0);
        cycle();
        @(negedge clk);
        do_reset();

        // randomized traffic; fetch obeys the registered stall protocol
        prev_stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 9) < 7) && !prev_stall,
                  $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 3);
            bus.fetch_instr = $urandom();
            @(negedge clk);
            prev_stall = bus.fetch_stall;
            model_check();
            model_update();
            @(posedge clk);
            #1;
        end

        // random traffic with stall ignored, exercising overflow
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 3) == 0, 1'b0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
